// File: rtl/rx_sched_pkg.sv
// Shared state encoding, default geometry and helpers for the correlation sweep scheduler.
package rx_sched_pkg;

    localparam int unsigned SEQ_LEN_DEF     = 255;
    localparam int unsigned ADDR_W_DEF      = 8;
    localparam int unsigned NUM_SEQ_DEF     = 16;
    localparam int unsigned CYC_PER_BIT_DEF = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSweep = 2'd1,
        StDone  = 2'd2
    } sched_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rx_sched_pacer.sv
// Hold-cycle pacer: counts 0..CYC_PER_BIT-1 while running, with a synchronous restart to 0.
module rx_sched_pacer
    import rx_sched_pkg::*;
#(
    parameter int unsigned CYC_PER_BIT = CYC_PER_BIT_DEF
) (
    input  logic crx_clk,
    input  logic rrx_rst_n,
    input  logic i_restart,
    input  logic i_run,
    output logic o_advance,
    output logic o_valid_arm
);

    localparam int unsigned CW = (CYC_PER_BIT > 1) ? $clog2(CYC_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYC_PER_BIT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n) begin
            r_count <= '0;
        end else if (i_restart || !i_run) begin
            r_count <= '0;
        end else begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign o_advance   = i_run && (r_count == LAST);
    // Armed on hold cycle 0; the registered valid therefore lands on hold cycle 1.
    assign o_valid_arm = i_run && (r_count == '0);

endmodule

// File: rtl/rx_correlation_scheduler.sv
// Correlation sweep scheduler: walks the sequence memory once per sample trigger.
// Optional statistics counters are built when RX_SCHED_STATS_EN is defined.
module rx_correlation_scheduler
    import rx_sched_pkg::*;
#(
    parameter int unsigned SEQ_LEN     = SEQ_LEN_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned NUM_SEQ     = NUM_SEQ_DEF,
    parameter int unsigned CYC_PER_BIT = CYC_PER_BIT_DEF
) (
    input  logic               crx_clk,
    input  logic               rrx_rst_n,
    input  logic               erx_en,
    input  logic               inew_sample_trig,
    input  logic [NUM_SEQ-1:0] iseq_mask,
    input  logic               iclr_overrun,
    output logic               oread_en,
    output logic [ADDR_W-1:0]  oread_address,
    output logic               obit_valid,
    output logic [ADDR_W-1:0]  obit_index,
    output logic [NUM_SEQ-1:0] oseq_enable,
    output logic               osweep_start,
    output logic               osweep_done,
    output logic               obusy,
`ifdef RX_SCHED_STATS_EN
    output logic               ooverrun,
    output logic [15:0]        osweep_count,
    output logic [15:0]        oabort_count
`else
    output logic               ooverrun
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SEQ_LEN - 1);

    sched_state_e       r_state;
    logic               r_read_en;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_bit_valid;
    logic [ADDR_W-1:0]  r_bit_index;
    logic [NUM_SEQ-1:0] r_seq_enable;
    logic               r_start;
    logic               r_done;
    logic               r_busy;
    logic               r_overrun;

    logic w_trig;
    logic w_in_sweep;
    logic w_advance;
    logic w_valid_arm;
    logic w_finish;
    logic w_abort;

    assign w_trig     = erx_en && inew_sample_trig;
    assign w_in_sweep = (r_state == StSweep);
    assign w_abort    = w_trig && w_in_sweep;
    assign w_finish   = w_in_sweep && w_advance && (r_addr == LAST_ADDR) && !w_trig;

    rx_sched_pacer #(
        .CYC_PER_BIT (CYC_PER_BIT)
    ) u_pacer (
        .crx_clk     (crx_clk),
        .rrx_rst_n   (rrx_rst_n),
        .i_restart   (w_trig || !erx_en),
        .i_run       (w_in_sweep),
        .o_advance   (w_advance),
        .o_valid_arm (w_valid_arm)
    );

    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n) begin
            r_state      <= StIdle;
            r_read_en    <= 1'b0;
            r_addr       <= '0;
            r_bit_valid  <= 1'b0;
            r_bit_index  <= '0;
            r_seq_enable <= '0;
            r_start      <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (!erx_en) begin
            r_state      <= StIdle;
            r_read_en    <= 1'b0;
            r_addr       <= '0;
            r_bit_valid  <= 1'b0;
            r_bit_index  <= '0;
            r_seq_enable <= '0;
            r_start      <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_start     <= 1'b0;
            r_done      <= 1'b0;
            r_bit_valid <= 1'b0;

            // Setting an overrun takes precedence over a clear in the same cycle.
            if (w_abort) begin
                r_overrun <= 1'b1;
            end else if (iclr_overrun) begin
                r_overrun <= 1'b0;
            end

            if (w_trig) begin
                r_state      <= StSweep;
                r_start      <= 1'b1;
                r_read_en    <= 1'b1;
                r_addr       <= '0;
                r_bit_index  <= '0;
                r_seq_enable <= iseq_mask;
                r_busy       <= 1'b1;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_read_en <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                    StSweep: begin
                        if (w_valid_arm) begin
                            r_bit_valid <= 1'b1;
                            r_bit_index <= r_addr;
                        end
                        if (w_advance) begin
                            if (r_addr == LAST_ADDR) begin
                                r_state     <= StDone;
                                r_done      <= 1'b1;
                                r_read_en   <= 1'b0;
                                r_addr      <= '0;
                                r_bit_index <= '0;
                            end else begin
                                r_addr <= r_addr + 1'b1;
                            end
                        end
                    end
                    StDone: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state   <= StIdle;
                        r_read_en <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef RX_SCHED_STATS_EN
    logic [15:0] r_sweep_count;
    logic [15:0] r_abort_count;

    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n) begin
            r_sweep_count <= '0;
            r_abort_count <= '0;
        end else if (!erx_en) begin
            r_sweep_count <= '0;
            r_abort_count <= '0;
        end else begin
            if (w_finish) begin
                r_sweep_count <= sat_inc16(r_sweep_count);
            end
            if (w_abort) begin
                r_abort_count <= sat_inc16(r_abort_count);
            end
        end
    end

    assign osweep_count = r_sweep_count;
    assign oabort_count = r_abort_count;
`endif

    assign oread_en      = r_read_en;
    assign oread_address = r_addr;
    assign obit_valid    = r_bit_valid;
    assign obit_index    = r_bit_index;
    assign oseq_enable   = r_seq_enable;
    assign osweep_start  = r_start;
    assign osweep_done   = r_done;
    assign obusy         = r_busy;
    assign ooverrun      = r_overrun;

endmodule

// File: tb/tb_rx_correlation_scheduler.sv
// Scoreboard bench for rx_correlation_scheduler: directed scenarios plus randomized triggers.
module tb_rx_correlation_scheduler;

    localparam int L  = 255;
    localparam int C  = 2;
    localparam int AW = 8;
    localparam int NS = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          trig = 1'b0;
    logic          clr = 1'b0;
    logic [NS-1:0] mask_in = '0;

    logic          read_en;
    logic [AW-1:0] read_addr;
    logic          bit_valid;
    logic [AW-1:0] bit_index;
    logic [NS-1:0] seq_enable;
    logic          sweep_start;
    logic          sweep_done;
    logic          busy;
    logic          overrun;
`ifdef RX_SCHED_STATS_EN
    logic [15:0]   sweep_count;
    logic [15:0]   abort_count;
`endif

    rx_correlation_scheduler dut (
        .crx_clk          (clk),
        .rrx_rst_n        (rst_n),
        .erx_en           (en),
        .inew_sample_trig (trig),
        .iseq_mask        (mask_in),
        .iclr_overrun     (clr),
        .oread_en         (read_en),
        .oread_address    (read_addr),
        .obit_valid       (bit_valid),
        .obit_index       (bit_index),
        .oseq_enable      (seq_enable),
        .osweep_start     (sweep_start),
        .osweep_done      (sweep_done),
        .obusy            (busy),
`ifdef RX_SCHED_STATS_EN
        .ooverrun         (overrun),
        .osweep_count     (sweep_count),
        .oabort_count     (abort_count)
`else
        .ooverrun         (overrun)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EvStart, EvValid, EvDone} ev_kind_e;
    typedef struct {
        int            cyc;
        ev_kind_e      kind;
        int            idx;
        logic [NS-1:0] mask;
    } ev_t;

    ev_t q[$];

    // Reference model: a sweep is fully described by its trigger cycle.
    int            m_t0 = 0;
    bit            m_live = 0;
    bit            m_ovr = 0;
    logic [NS-1:0] m_mask = '0;
    int            m_done_cnt = 0;
    int            m_abort_cnt = 0;
    bit            cur_en = 0;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic bit in_sweep(input int t);
        return m_live && (t - m_t0 >= 1) && (t - m_t0 <= C * L);
    endfunction

    function automatic bit in_done(input int t);
        return m_live && (t - m_t0 == C * L + 1);
    endfunction

    task automatic drop_after(input int t);
        while (q.size() > 0 && q[$].cyc > t) void'(q.pop_back());
    endtask

    task automatic model_reset();
        q.delete();
        m_live = 0;
        m_ovr = 0;
        m_mask = '0;
        m_done_cnt = 0;
        m_abort_cnt = 0;
    endtask

    // Drive inputs for the current cycle and advance the model to the next one.
    task automatic apply(input bit t, input bit e, input bit c, input logic [NS-1:0] m);
        int tc;
        tc = cyc;
        if (!e) begin
            m_live = 0;
            m_ovr = 0;
            m_mask = '0;
            m_done_cnt = 0;
            m_abort_cnt = 0;
            drop_after(tc);
        end else if (t) begin
            if (in_sweep(tc)) begin
                m_ovr = 1;
                m_abort_cnt++;
                drop_after(tc);
            end else if (c) begin
                m_ovr = 0;
            end
            m_t0 = tc;
            m_live = 1;
            m_mask = m;
            q.push_back('{tc + 1, EvStart, 0, m});
            for (int k = 0; k < L; k++) q.push_back('{tc + 2 + C * k, EvValid, k, '0});
            q.push_back('{tc + 1 + C * L, EvDone, 0, '0});
        end else if (c) begin
            m_ovr = 0;
        end
        trig = t;
        en = e;
        clr = c;
        mask_in = m;
        cur_en = e;
    endtask

    task automatic wait_cyc(input int t);
        @(negedge clk);
        while (cyc < t) begin
            apply(0, cur_en, ($urandom_range(0, 31) == 0), NS'($urandom));
            @(negedge clk);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {read_en, read_addr, bit_valid, bit_index, seq_enable, sweep_start,
                   sweep_done, busy, overrun}, '0);
    endtask

`ifdef RX_SCHED_STATS_EN
    task automatic chk_stats(input string name);
        chk({name, "_sweeps"}, 64'(sweep_count), 64'(m_done_cnt));
        chk({name, "_aborts"}, 64'(abort_count), 64'(m_abort_cnt));
    endtask
`endif

    // Monitor: pops expected events for this cycle and compares against DUT outputs.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            begin
                bit            e_start;
                bit            e_valid;
                bit            e_done;
                int            e_idx;
                logic [NS-1:0] e_mask;
                int            t;
                int            exp_addr;
                bit            sw;
                ev_t           ev;
                e_start = 0;
                e_valid = 0;
                e_done = 0;
                e_idx = 0;
                e_mask = '0;
                t = cyc;
                while (q.size() > 0 && q[0].cyc <= t) begin
                    ev = q.pop_front();
                    if (ev.cyc < t) begin
                        chk("stale_event", 64'(ev.cyc), 64'(t));
                    end else begin
                        case (ev.kind)
                            EvStart: begin e_start = 1; e_mask = ev.mask; end
                            EvValid: begin e_valid = 1; e_idx = ev.idx; end
                            default: e_done = 1;
                        endcase
                    end
                end
                if (sweep_start || e_start)
                    chk("sweep_start", {sweep_start, seq_enable}, {e_start, e_mask});
                if (bit_valid || e_valid)
                    chk("bit_valid", {bit_valid, bit_index}, {e_valid, AW'(e_idx)});
                if (sweep_done || e_done) begin
                    chk("sweep_done", 64'(sweep_done), 64'(e_done));
                    if (e_done) m_done_cnt++;
                end
                sw = in_sweep(t);
                exp_addr = sw ? (t - m_t0 - 1) / C : 0;
                chk("cycle_state",
                    {read_en, read_addr, busy, overrun, seq_enable, (sw ? AW'(0) : bit_index)},
                    {sw, AW'(exp_addr), (sw || in_done(t)), m_ovr, m_mask, AW'(0)});
            end
        end
    end

    initial begin
        int gap;
        int t;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset_outputs");
        rst_n = 1'b1;

        // Basic sweep, trigger in DONE cycle, then abort of the follow-on sweep.
        wait_cyc(5);
        apply(0, 1, 0, '0);
        wait_cyc(10);
        apply(1, 1, 0, 16'hA5A5);
        wait_cyc(10 + C * L + 1);
        apply(1, 1, 0, 16'h1234);
        wait_cyc(10 + C * L + 1 + 190);
        apply(1, 1, 0, 16'h0F0F);
        wait_cyc(1300);
        apply(0, 1, 1, '0);
        wait_cyc(1310);
        chk("overrun_cleared", 64'(overrun), 64'(0));
`ifdef RX_SCHED_STATS_EN
        chk_stats("stats_after_directed");
`endif

        // Enable dropped mid-sweep; trigger while disabled is ignored.
        wait_cyc(1320);
        apply(1, 1, 0, 16'hFFFF);
        wait_cyc(1410);
        apply(0, 0, 0, '0);
        wait_cyc(1415);
        apply(1, 0, 0, 16'h5555);
        wait_cyc(1416);
        apply(0, 0, 0, '0);
        #1 chk_all_zero("disabled_outputs");
        wait_cyc(1420);
        apply(0, 1, 0, '0);

        // Asynchronous reset between clock edges during a sweep.
        wait_cyc(1430);
        apply(1, 1, 0, 16'hC3C3);
        wait_cyc(1500);
        apply(0, 1, 0, '0);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        trig = 1'b0;
        model_reset();
        wait_cyc(1504);
        apply(0, 1, 0, '0);
        rst_n = 1'b1;
        wait_cyc(1510);
        apply(1, 1, 0, 16'h00FF);

        // Randomized trigger spacing: aborts, DONE-cycle retriggers, and gaps.
        t = 1510;
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
                0:       gap = $urandom_range(20, 500);
                1:       gap = C * L + 1;
                2:       gap = $urandom_range(C * L + 2, C * L + 40);
                default: gap = $urandom_range(1, 5);
            endcase
            t = t + gap;
            wait_cyc(t);
            apply(1, 1, ($urandom_range(0, 1) == 1), NS'($urandom));
        end
        wait_cyc(t + C * L + 20);
        chk("queue_drained", 64'(q.size()), 64'(0));
`ifdef RX_SCHED_STATS_EN
        chk_stats("stats_random");
        apply(0, 0, 0, '0);
        wait_cyc(t + C * L + 22);
        chk_stats("stats_cleared");
`endif
        apply(0, 0, 0, '0);
        wait_cyc(t + C * L + 25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
